// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexed scan driver for a four-digit seven-segment display.
//
// A prescaler divides Clock down to one Tick per digit slot. A 2-bit index walks
// the four digits. New values are captured into a shadow register on Load. They
// are copied into the display register only at the end of a full frame, so a
// refresh never shows half of an old value and half of a new one.
//
// Optional feature, selected at compile time:
//   SSD_LEADING_ZERO_BLANK_EN - turn off the anodes of the leading zero digits.
//                               Digit 0 always stays lit. When the macro is
//                               undefined, all four digits are always enabled.
module ssd_scan_driver #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic [15:0] Value,
    input  logic        Load,
    input  logic        Blank,
    output logic [3:0]  Digit,
    output logic [3:0]  Anode,
    output logic        Pending
);

    // A counter of this width is wide enough to hold CLK_DIV-1.
    // CLK_DIV=1 still gets a one-bit counter, which simply stays at 0.
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] presc;
    logic [1:0]       index;
    logic [15:0]      display;
    logic [15:0]      shadow;
    logic             pending;

    logic             tick;
    logic             frame_end;
    logic [3:0]       slot_onehot;
    logic [3:0]       digit_en;

    assign tick      = (presc == CNT_MAX);
    assign frame_end = tick && (index == 2'd3);
    assign Pending   = pending;

    // Prescaler: counts 0..CLK_DIV-1, then wraps to 0 on the Tick cycle.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + CNT_W'(1);
        end
    end

    // Digit index: advances once per Tick and wraps naturally from 3 back to 0.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            index <= 2'd0;
        end else if (tick) begin
            index <= index + 2'd1;
        end
    end

    // Capture and commit. The display register loads the value that was pending
    // before this edge. A Load on the same edge lands in the shadow register and
    // keeps Pending set for the next frame.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            display <= 16'h0000;
            shadow  <= 16'h0000;
            pending <= 1'b0;
        end else begin
            if (frame_end && pending) begin
                display <= shadow;
            end
            if (Load) begin
                shadow  <= Value;
                pending <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end
        end
    end

    // Nibble select: decoded directly from registered state, with no extra pipeline stage.
    always_comb begin
        Digit = 4'h0;
        unique case (index)
            2'd0: Digit = display[3:0];
            2'd1: Digit = display[7:4];
            2'd2: Digit = display[11:8];
            2'd3: Digit = display[15:12];
            default: Digit = 4'h0;
        endcase
    end

    // One-hot position of the digit currently being scanned.
    always_comb begin
        slot_onehot = 4'b0000;
        unique case (index)
            2'd0: slot_onehot = 4'b0001;
            2'd1: slot_onehot = 4'b0010;
            2'd2: slot_onehot = 4'b0100;
            2'd3: slot_onehot = 4'b1000;
            default: slot_onehot = 4'b0000;
        endcase
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // Enable mask covering every position up to the most significant nonzero nibble.
    always_comb begin
        digit_en = 4'b0001;
        if (display[15:12] != 4'h0) begin
            digit_en = 4'b1111;
        end else if (display[11:8] != 4'h0) begin
            digit_en = 4'b0111;
        end else if (display[7:4] != 4'h0) begin
            digit_en = 4'b0011;
        end
    end
`else
    // All positions are always enabled; only Blank can turn the anodes off.
    always_comb begin
        digit_en = 4'b1111;
    end
`endif

    // Active-low anode drive. Blank overrides the drive without disturbing the scan state.
    always_comb begin
        Anode = 4'b1111;
        if (!Blank) begin
            Anode = ~(slot_onehot & digit_en);
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (CLK_DIV=4 main instance, CLK_DIV=1 side instance).
// A timeline table holds per-cycle inputs and the expected outputs after each edge.
// Expected values are queued when the inputs are driven and popped when the outputs are sampled.
module tb_ssd_scan_driver;

    typedef struct {
        logic        load;
        logic [15:0] value;
        logic        blank;
        logic [3:0]  anode;
        logic [3:0]  digit;
        logic        pend;
    } vec_t;

    typedef struct {
        logic [3:0] anode;
        logic [3:0] digit;
        logic       pend;
    } exp_t;

    localparam int NVEC = 128;

    logic        Clock;
    logic        ResetN;
    logic [15:0] Value;
    logic        Load;
    logic        Blank;
    logic [3:0]  Digit;
    logic [3:0]  Anode;
    logic        Pending;
    logic [3:0]  Digit1;
    logic [3:0]  Anode1;
    logic        Pending1;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   checks;
    int   failures;

    ssd_scan_driver #(.CLK_DIV(4)) u_dut (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .Value   (Value),
        .Load    (Load),
        .Blank   (Blank),
        .Digit   (Digit),
        .Anode   (Anode),
        .Pending (Pending)
    );

    ssd_scan_driver #(.CLK_DIV(1)) u_div1 (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .Value   (Value),
        .Load    (Load),
        .Blank   (Blank),
        .Digit   (Digit1),
        .Anode   (Anode1),
        .Pending (Pending1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Watchdog: the run is a fixed number of cycles, so this should never trigger.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    // Digits allowed to light for a given display value.
    function automatic logic [3:0] en_mask(input logic [15:0] d);
        logic [3:0] m;
        m = 4'b1111;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        m = 4'b0001;
        for (int i = 1; i < 4; i++) begin
            if (d[4*i +: 4] != 4'h0) m = 4'((5'd1 << (i + 1)) - 5'd1);
        end
`endif
        return m;
    endfunction

    function automatic logic [3:0] exp_anode(input int idx, input logic [15:0] d,
                                             input logic bl);
        logic [3:0] one;
        if (bl) return 4'b1111;
        one = 4'(4'b0001 << idx);
        return ~(one & en_mask(d));
    endfunction

    function automatic logic [3:0] exp_digit(input int idx, input logic [15:0] d);
        return d[idx*4 +: 4];
    endfunction

    // Expected state after edge e of the scripted timeline (edges counted from reset release).
    function automatic vec_t timeline(input int e);
        vec_t        v;
        int          idx;
        logic [15:0] disp;
        logic        p;
        logic        bl;
        idx = (e / 4) % 4;
        if (e < 16)       disp = 16'h0000;
        else if (e < 32)  disp = 16'h1234;
        else if (e < 48)  disp = 16'h5678;
        else if (e < 64)  disp = 16'h1111;
        else if (e < 96)  disp = 16'h9999;
        else if (e < 112) disp = 16'h0042;
        else              disp = 16'h0000;
        p = (e >= 5 && e <= 15) || (e >= 21 && e <= 31) || (e >= 37 && e <= 63) ||
            (e >= 81 && e <= 95) || (e >= 100 && e <= 111);
        bl = (e >= 69 && e <= 78);
        v.load  = 1'b0;
        v.value = 16'h0000;
        v.blank = bl;
        v.anode = exp_anode(idx, disp, bl);
        v.digit = exp_digit(idx, disp);
        v.pend  = p;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, then compare after the edge.
    task automatic step(input string tag, input logic ld, input logic [15:0] val,
                        input logic bl, input logic [3:0] ea, input logic [3:0] ed,
                        input logic ep);
        exp_t e;
        exp_t got;
        Load  = ld;
        Value = val;
        Blank = bl;
        e.anode = ea;
        e.digit = ed;
        e.pend  = ep;
        sb.push_back(e);
        @(posedge Clock);
        @(negedge Clock);
        got = sb.pop_front();
        check({tag, " anode"}, 16'(Anode), 16'(got.anode));
        check({tag, " digit"}, 16'(Digit), 16'(got.digit));
        check({tag, " pending"}, 16'(Pending), 16'(got.pend));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ResetN   = 1'b0;
        Load     = 1'b0;
        Value    = 16'h0000;
        Blank    = 1'b0;

        // Build the timeline: a Load on edge e sits in vecs[e-1].
        for (int e = 1; e <= NVEC; e++) vecs[e-1] = timeline(e);
        vecs[4].load  = 1'b1; vecs[4].value  = 16'h1234;
        vecs[20].load = 1'b1; vecs[20].value = 16'hAAAA;
        vecs[25].load = 1'b1; vecs[25].value = 16'h5678;
        vecs[36].load = 1'b1; vecs[36].value = 16'h1111;
        vecs[47].load = 1'b1; vecs[47].value = 16'h9999;  // lands on a frame boundary
        vecs[80].load = 1'b1; vecs[80].value = 16'h0042;
        vecs[99].load = 1'b1; vecs[99].value = 16'h0000;

        // Reset state, before any clock edge.
        #3;
        check("reset anode", 16'(Anode), 16'(exp_anode(0, 16'h0000, 1'b0)));
        check("reset digit", 16'(Digit), 16'h0);
        check("reset pending", 16'(Pending), 16'h0);
        Blank = 1'b1;
        #1;
        check("reset blank anode", 16'(Anode), 16'hF);
        Blank = 1'b0;
        // Load held across an edge while reset is low must not capture.
        Load  = 1'b1;
        Value = 16'hFFFF;
        @(negedge Clock);
        check("reset load ignored", 16'(Pending), 16'h0);
        check("reset hold anode", 16'(Anode), 16'(exp_anode(0, 16'h0000, 1'b0)));
        Load   = 1'b0;
        Value  = 16'h0000;
        ResetN = 1'b1;

        for (int r = 0; r < NVEC; r++) begin
            step($sformatf("vec%0d", r), vecs[r].load, vecs[r].value, vecs[r].blank,
                 vecs[r].anode, vecs[r].digit, vecs[r].pend);
        end

        // Edge 129: capture a value that is later discarded by a mid-frame reset.
        step("pre-reset load", 1'b1, 16'h5555, 1'b0, exp_anode(0, 16'h0000, 1'b0), 4'h0, 1'b1);
        Load  = 1'b0;
        Value = 16'h0000;
        #2;
        ResetN = 1'b0;
        #1;
        check("async reset anode", 16'(Anode), 16'(exp_anode(0, 16'h0000, 1'b0)));
        check("async reset digit", 16'(Digit), 16'h0);
        check("async reset pending", 16'(Pending), 16'h0);
        check("async reset div1 anode", 16'(Anode1), 16'(exp_anode(0, 16'h0000, 1'b0)));
        Blank = 1'b1;
        #1;
        check("async reset blank anode", 16'(Anode), 16'hF);
        Blank = 1'b0;
        @(negedge Clock);
        ResetN = 1'b1;

        // Restart from index 0; the discarded 5555 must never be committed.
        for (int e = 1; e <= 17; e++) begin
            step($sformatf("restart%0d", e), 1'b0, 16'h0000, 1'b0,
                 exp_anode((e / 4) % 4, 16'h0000, 1'b0), 4'h0, 1'b0);
            if (e <= 4) begin
                check($sformatf("div1 anode%0d", e), 16'(Anode1),
                      16'(exp_anode(e % 4, 16'h0000, 1'b0)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
